// File: rtl/risc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : risc_ctrl_pkg
//  Description : Shared state encoding, instruction field positions, opcode /
//                op constants and ALU operation codes for risc_controller.
//                The HALT state exists only when RISC_CTRL_ILLEGAL_TRAP_EN is
//                defined.
//  Revision    : 1.0 - initial release
// ============================================================================
package risc_ctrl_pkg;

  // Controller states; HALT is the illegal-instruction trap state.
  typedef enum logic [2:0] {
    S_WAIT   = 3'd0,
    S_DECODE = 3'd1,
    S_GET_A  = 3'd2,
    S_GET_B  = 3'd3,
    S_ALU    = 3'd4,
    S_WR_REG = 3'd5,
    S_WR_IMM = 3'd6
`ifdef RISC_CTRL_ILLEGAL_TRAP_EN
    ,
    S_HALT   = 3'd7
`endif
  } state_e;

  // Instruction field bit positions
  localparam int OPCODE_HI = 15;
  localparam int OPCODE_LO = 13;
  localparam int OP_HI     = 12;
  localparam int OP_LO     = 11;
  localparam int RN_HI     = 10;
  localparam int RN_LO     = 8;
  localparam int RD_HI     = 7;
  localparam int RD_LO     = 5;
  localparam int SH_HI     = 4;
  localparam int SH_LO     = 3;
  localparam int RM_HI     = 2;
  localparam int RM_LO     = 0;
  localparam int IMM_HI    = 7;
  localparam int IMM_LO    = 0;

  // Opcode classes
  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  // op sub-codes
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;

  // ALU operation codes
  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_AND  = 2'b10;
  localparam logic [1:0] ALU_NOTB = 2'b11;

endpackage : risc_ctrl_pkg
`default_nettype wire

// File: rtl/instr_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : instr_decoder
//  Description : Combinational field extraction, imm8 sign extension and
//                legal/illegal classification of the held instruction.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_decoder
  import risc_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] instr,
  output logic [2:0]       rn,
  output logic [2:0]       rd,
  output logic [2:0]       rm,
  output logic [1:0]       sh,
  output logic [1:0]       alu_op,
  output logic [WIDTH-1:0] sximm8,
  output logic             is_mov_imm,
  output logic             is_mov_reg,
  output logic             is_alu,
  output logic             is_cmp,
  output logic             is_mvn,
  output logic             legal
);

  logic [2:0] opcode;
  logic [1:0] op;
  logic [7:0] imm8;

  assign opcode = instr[OPCODE_HI:OPCODE_LO];
  assign op     = instr[OP_HI:OP_LO];
  assign rn     = instr[RN_HI:RN_LO];
  assign rd     = instr[RD_HI:RD_LO];
  assign sh     = instr[SH_HI:SH_LO];
  assign rm     = instr[RM_HI:RM_LO];
  assign imm8   = instr[IMM_HI:IMM_LO];
  assign sximm8 = {{(WIDTH-8){imm8[7]}}, imm8};

  // Classify the instruction and pick the ALU operation it needs
  always_comb begin
    is_mov_imm = (opcode == OPC_MOV) && (op == OP_MOV_IMM);
    is_mov_reg = (opcode == OPC_MOV) && (op == OP_MOV_REG);
    is_alu     = (opcode == OPC_ALU);
    is_cmp     = is_alu && (op == OP_CMP);
    is_mvn     = is_alu && (op == OP_MVN);
    legal      = is_mov_imm || is_mov_reg || is_alu;
    alu_op     = ALU_ADD;
    if (is_alu) begin
      case (op)
        OP_ADD:  alu_op = ALU_ADD;
        OP_CMP:  alu_op = ALU_SUB;
        OP_AND:  alu_op = ALU_AND;
        default: alu_op = ALU_NOTB;
      endcase
    end
  end

endmodule : instr_decoder
`default_nettype wire

// File: rtl/risc_controller.sv
`default_nettype none
// ============================================================================
//  Module      : risc_controller
//  Description : Moore FSM sequencing the 16-bit RISC datapath through
//                read, ALU and write-back phases, one phase per clock.
//                Optional feature macro: RISC_CTRL_ILLEGAL_TRAP_EN - when
//                defined, undefined encodings trap into HALT (err=1) until
//                reset; otherwise they execute as a NOP.
//  Revision    : 1.0 - initial release
// ============================================================================
module risc_controller
  import risc_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s,
  input  logic             load,
  input  logic [WIDTH-1:0] instr_in,
  output logic [2:0]       readnum,
  output logic [2:0]       writenum,
  output logic             loada,
  output logic             loadb,
  output logic             loadc,
  output logic             loads,
  output logic             write,
  output logic             vsel,
  output logic             asel,
  output logic             bsel,
  output logic [1:0]       shift,
  output logic [1:0]       ALUop,
  output logic [WIDTH-1:0] datapath_in,
  output logic             w,
  output logic             err
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] ir_q, ir_d;

  logic [2:0] rn, rd, rm;
  logic [1:0] sh, alu_op;
  logic       is_mov_imm, is_mov_reg, is_alu, is_cmp, is_mvn, legal;

  instr_decoder #(
    .WIDTH (WIDTH)
  ) u_dec (
    .instr      (ir_q),
    .rn         (rn),
    .rd         (rd),
    .rm         (rm),
    .sh         (sh),
    .alu_op     (alu_op),
    .sximm8     (datapath_in),
    .is_mov_imm (is_mov_imm),
    .is_mov_reg (is_mov_reg),
    .is_alu     (is_alu),
    .is_cmp     (is_cmp),
    .is_mvn     (is_mvn),
    .legal      (legal)
  );

  // State and instruction register; reset wins over any pending load
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_WAIT;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  // IR loads only while idle, so a load during execution cannot corrupt it
  always_comb begin
    ir_d = ir_q;
    if ((state_q == S_WAIT) && load) ir_d = instr_in;
  end

  // Next-state sequencing
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_WAIT:   if (s) state_d = S_DECODE;
      S_DECODE: begin
        if (is_mov_imm)               state_d = S_WR_IMM;
        else if (is_mov_reg || is_mvn) state_d = S_GET_B;
        else if (is_alu)              state_d = S_GET_A;
`ifdef RISC_CTRL_ILLEGAL_TRAP_EN
        else                          state_d = S_HALT;
`else
        else                          state_d = S_WAIT;
`endif
      end
      S_GET_A:  state_d = S_GET_B;
      S_GET_B:  state_d = S_ALU;
      S_ALU:    state_d = is_cmp ? S_WAIT : S_WR_REG;
      S_WR_REG: state_d = S_WAIT;
      S_WR_IMM: state_d = S_WAIT;
`ifdef RISC_CTRL_ILLEGAL_TRAP_EN
      S_HALT:   state_d = S_HALT;
`endif
      default:  state_d = S_WAIT;
    endcase
  end

  // Moore outputs: every strobe defaults low, each state raises its own
  always_comb begin
    readnum  = 3'd0;
    writenum = 3'd0;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    write    = 1'b0;
    vsel     = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    shift    = 2'b00;
    ALUop    = 2'b00;
    w        = 1'b0;
    err      = 1'b0;
    case (state_q)
      S_WAIT:  w = 1'b1;
      S_GET_A: begin
        readnum = rn;
        loada   = 1'b1;
      end
      S_GET_B: begin
        readnum = rm;
        loadb   = 1'b1;
      end
      S_ALU: begin
        shift = sh;
        ALUop = is_alu ? alu_op : ALU_ADD;
        asel  = is_mov_reg || is_mvn;
        loadc = !is_cmp;
        loads = is_cmp;
      end
      S_WR_REG: begin
        vsel     = 1'b0;
        writenum = rd;
        write    = 1'b1;
      end
      S_WR_IMM: begin
        vsel     = 1'b1;
        writenum = rn;
        write    = 1'b1;
      end
`ifdef RISC_CTRL_ILLEGAL_TRAP_EN
      S_HALT:  err = 1'b1;
`endif
      default: ;
    endcase
  end

endmodule : risc_controller
`default_nettype wire

// File: tb/tb_risc_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_risc_controller
//  Description : Directed self-checking bench for risc_controller.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_risc_controller;

  logic        clk = 1'b0;
  logic        reset, s, load;
  logic [15:0] instr_in;
  logic [2:0]  readnum, writenum;
  logic        loada, loadb, loadc, loads, write, vsel, asel, bsel, w, err;
  logic [1:0]  shift, ALUop;
  logic [15:0] datapath_in;

  int checks = 0;
  int errors = 0;

  // strobe bundle: loada loadb loadc loads write vsel asel bsel w err
  logic [9:0] strb;
  assign strb = {loada, loadb, loadc, loads, write, vsel, asel, bsel, w, err};

  localparam logic [9:0] IDLE   = 10'b0000000010;
  localparam logic [9:0] BUSY   = 10'b0000000000;
  localparam logic [9:0] LDA    = 10'b1000000000;
  localparam logic [9:0] LDB    = 10'b0100000000;
  localparam logic [9:0] LDC    = 10'b0010000000;
  localparam logic [9:0] LDC_AS = 10'b0010001000;
  localparam logic [9:0] LDS    = 10'b0001000000;
  localparam logic [9:0] WRR    = 10'b0000100000;
  localparam logic [9:0] WRI    = 10'b0000110000;
  localparam logic [9:0] HALTED = 10'b0000000001;

  risc_controller #(.WIDTH(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .s           (s),
    .load        (load),
    .instr_in    (instr_in),
    .readnum     (readnum),
    .writenum    (writenum),
    .loada       (loada),
    .loadb       (loadb),
    .loadc       (loadc),
    .loads       (loads),
    .write       (write),
    .vsel        (vsel),
    .asel        (asel),
    .bsel        (bsel),
    .shift       (shift),
    .ALUop       (ALUop),
    .datapath_in (datapath_in),
    .w           (w),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    reset = 1'b1; s = 1'b0; load = 1'b0; instr_in = 16'h0000;
    tick; tick;
    reset = 1'b0;
    chk("rst_strb", strb, IDLE);
    chk("rst_dpin", datapath_in, 16'h0000);
    chk("rst_idx", {readnum, writenum, shift, ALUop}, 10'd0);

    // MOV R0,#-3 : load and start together; s held into DECODE is ignored
    load = 1'b1; instr_in = 16'hD0FD; s = 1'b1;
    tick;                                   // DECODE
    load = 1'b0;
    chk("movi_dec_strb", strb, BUSY);
    chk("movi_dpin", datapath_in, 16'hFFFD);
    tick;                                   // WR_IMM
    s = 1'b0;
    chk("movi_wr_strb", strb, WRI);
    chk("movi_wr_num", writenum, 3'd0);
    tick;                                   // WAIT, 3 edges after s
    chk("movi_done", strb, IDLE);

    // ADD R2,R1,R0 LSL1 : load first, then start; load during run ignored
    load = 1'b1; instr_in = 16'hA148;
    tick;
    load = 1'b0;
    chk("add_loaded_idle", strb, IDLE);
    s = 1'b1;
    tick;                                   // DECODE
    s = 1'b0;
    load = 1'b1; instr_in = 16'hD0FD;
    chk("add_dec_strb", strb, BUSY);
    tick;                                   // GET_A
    chk("add_geta", {strb, readnum}, {LDA, 3'd1});
    tick;                                   // GET_B
    chk("add_getb", {strb, readnum}, {LDB, 3'd0});
    tick;                                   // ALU
    chk("add_alu", {strb, shift, ALUop}, {LDC, 2'b01, 2'b00});
    tick;                                   // WR_REG
    chk("add_wr", {strb, writenum}, {WRR, 3'd2});
    load = 1'b0;
    tick;                                   // WAIT
    chk("add_done", strb, IDLE);
    chk("add_ir_kept", datapath_in, 16'h0048);

    // CMP R3,R4
    load = 1'b1; instr_in = 16'hAB04; s = 1'b1;
    tick;
    load = 1'b0; s = 1'b0;
    chk("cmp_dec", strb, BUSY);
    tick;
    chk("cmp_geta", {strb, readnum}, {LDA, 3'd3});
    tick;
    chk("cmp_getb", {strb, readnum}, {LDB, 3'd4});
    tick;
    chk("cmp_alu", {strb, shift, ALUop}, {LDS, 2'b00, 2'b01});
    tick;
    chk("cmp_done", strb, IDLE);

    // MVN R7,R1
    load = 1'b1; instr_in = 16'hB8E1; s = 1'b1;
    tick;
    load = 1'b0; s = 1'b0;
    chk("mvn_dec", strb, BUSY);
    tick;
    chk("mvn_getb", {strb, readnum}, {LDB, 3'd1});
    tick;
    chk("mvn_alu", {strb, ALUop}, {LDC_AS, 2'b11});
    tick;
    chk("mvn_wr", {strb, writenum}, {WRR, 3'd7});
    tick;
    chk("mvn_done", strb, IDLE);

    // MOV R5,R3 LSR(sh=10)
    load = 1'b1; instr_in = 16'hC0B3; s = 1'b1;
    tick;
    load = 1'b0; s = 1'b0;
    tick;
    chk("movr_getb", {strb, readnum}, {LDB, 3'd3});
    tick;
    chk("movr_alu", {strb, shift, ALUop}, {LDC_AS, 2'b10, 2'b00});
    tick;
    chk("movr_wr", {strb, writenum}, {WRR, 3'd5});
    tick;
    chk("movr_done", strb, IDLE);

    // AND R0,R0,R0 : check ALUop only
    load = 1'b1; instr_in = 16'hB000; s = 1'b1;
    tick;
    load = 1'b0; s = 1'b0;
    tick; tick; tick;                       // GET_A, GET_B, ALU
    chk("and_alu", {strb, ALUop}, {LDC, 2'b10});
    tick; tick;
    chk("and_done", strb, IDLE);

    // Reset during GET_B of ADD
    load = 1'b1; instr_in = 16'hA148; s = 1'b1;
    tick;
    load = 1'b0; s = 1'b0;
    tick; tick;                             // GET_A, GET_B
    chk("rstmid_getb", strb, LDB);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("rstmid_strb", strb, IDLE);
    chk("rstmid_dpin", datapath_in, 16'h0000);
    tick;
    chk("rstmid_nowrite", strb, IDLE);

    // Undefined encoding 0x0000
    load = 1'b1; instr_in = 16'h0000; s = 1'b1;
    tick;                                   // DECODE
    load = 1'b0; s = 1'b0;
    chk("ill_dec", strb, BUSY);
    tick;
`ifdef RISC_CTRL_ILLEGAL_TRAP_EN
    chk("ill_halt", strb, HALTED);
    s = 1'b1; load = 1'b1; instr_in = 16'hD0FD;
    tick; tick; tick;
    s = 1'b0; load = 1'b0;
    chk("ill_halt_sticky", strb, HALTED);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("ill_reset_clear", strb, IDLE);
`else
    chk("ill_nop_done", strb, IDLE);
    tick;
    chk("ill_nop_idle", strb, IDLE);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_risc_controller
`default_nettype wire
